// File: rtl/i2c_phase_ctrl.sv
// Bit-level I2C sequencer: runs START/STOP/WRITE/READ as four quarter-phases
// on the SCL/SDA open-drain enables, with SCL stretching and SDA sampling.
module i2c_phase_ctrl #(
  parameter int CLK_IN   = 100_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       din_i,
  output logic       rsp_valid_o,
  output logic       rsp_bit_o,
  output logic       arb_lost_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  localparam int QDIV = CLK_IN / (4 * SCL_FREQ);
  localparam int QW   = (QDIV < 2) ? 1 : $clog2(QDIV);
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  generate
    if (QDIV < 2) begin : g_bad_qdiv
      $error("i2c_phase_ctrl: QDIV must be at least 2");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  // {scl_oe, sda_oe} for a given command and phase
  function automatic logic [1:0] phase_oe(input logic [1:0] cmd, input logic d,
                                          input logic [1:0] ph);
    logic edge_ph;
    edge_ph = (ph == 2'd0) || (ph == 2'd3);
    case (cmd)
      CMD_START: case (ph)
                   2'd0:    phase_oe = 2'b10;
                   2'd1:    phase_oe = 2'b00;
                   2'd2:    phase_oe = 2'b01;
                   default: phase_oe = 2'b11;
                 endcase
      CMD_STOP:  case (ph)
                   2'd0:    phase_oe = 2'b11;
                   2'd1:    phase_oe = 2'b01;
                   default: phase_oe = 2'b00;
                 endcase
      CMD_WRITE: phase_oe = {edge_ph, ~d};
      default:   phase_oe = {edge_ph, 1'b0};
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          din_q, din_d;
  logic          sample_q, sample_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_bit_q, rsp_bit_d;
  logic          arb_lost_q, arb_lost_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          stretch, tick;

  // A released SCL still read low means a slave is stretching the clock.
  assign stretch = ~scl_oe_q & ~scl_i;
  assign tick    = (state_q == RUN) && !stretch && (qcnt_q == QLAST);

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    phase_d     = phase_q;
    cmd_d       = cmd_q;
    din_d       = din_q;
    sample_d    = sample_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    arb_lost_d  = 1'b0;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d                = RUN;
          cmd_d                  = cmd_i;
          din_d                  = din_i;
          phase_d                = 2'd0;
          qcnt_d                 = '0;
          {scl_oe_d, sda_oe_d}   = phase_oe(cmd_i, din_i, 2'd0);
        end
      end
      default: begin
        if (tick) begin
          qcnt_d = '0;
          if (phase_q == 2'd2 && cmd_q[1]) sample_d = sda_i;
          if (phase_q == 2'd3) begin
            state_d = IDLE;
            if (cmd_q[1]) begin
              rsp_valid_d = 1'b1;
              rsp_bit_d   = sample_q;
              arb_lost_d  = (cmd_q == CMD_WRITE) && din_q && !sample_q;
            end
          end else begin
            phase_d              = phase_q + 2'd1;
            {scl_oe_d, sda_oe_d} = phase_oe(cmd_q, din_q, phase_q + 2'd1);
          end
        end else if (!stretch) begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      qcnt_q      <= '0;
      phase_q     <= 2'd0;
      cmd_q       <= 2'b00;
      din_q       <= 1'b0;
      sample_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      arb_lost_q  <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      phase_q     <= phase_d;
      cmd_q       <= cmd_d;
      din_q       <= din_d;
      sample_q    <= sample_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      arb_lost_q  <= arb_lost_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_bit_o   = rsp_bit_q;
  assign arb_lost_o  = arb_lost_q;
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;

endmodule

// File: doc/i2c_phase_ctrl.md
Name: i2c_phase_ctrl

Overview:
Bit-level I2C bus sequencer that drives the SCL/SDA open-drain enables from a quarter-period tick. It accepts one-bit commands (START, STOP, WRITE, READ) over a valid/ready handshake and runs each command as four equal quarter-phases. It supports SCL clock stretching and returns sampled SDA bits. It sits between the byte-level I2C master FSM and the pad open-drain buffers.

Parameters:
CLK_IN, 100_000_000, system clock frequency in Hz
SCL_FREQ, 100_000, target SCL frequency in Hz; QDIV = CLK_IN/(4*SCL_FREQ), elaboration error if QDIV < 2

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready (idle)
cmd_i  in  2  00 START, 01 STOP, 10 WRITE, 11 READ
din_i  in  1  bit to transmit for WRITE, sampled with the command
rsp_valid_o  out  1  one-cycle pulse: WRITE/READ completed
rsp_bit_o  out  1  SDA value sampled in the bit, held until the next response
arb_lost_o  out  1  one-cycle pulse with rsp_valid_o: WRITE of 1 sampled 0
busy_o  out  1  command in progress
scl_i  in  1  synchronised SCL pad level
sda_i  in  1  synchronised SDA pad level
scl_oe_o  out  1  1 = pull SCL low
sda_oe_o  out  1  1 = pull SDA low

Behaviour:
- Reset (async, any time, including mid-command): state IDLE, cmd_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_bit_o=0, arb_lost_o=0, scl_oe_o=0, sda_oe_o=0, counters cleared. A command in progress is abandoned.
- States: IDLE, RUN. cmd_ready_o = (state==IDLE).
- Accept: cmd_valid_i & cmd_ready_o at edge N. cmd_i and din_i are latched. RUN starts with phase 0 and qcnt=0 at N+1.
- qcnt counts 0..QDIV-1 in RUN. The tick is qcnt==QDIV-1. On a tick, qcnt wraps to 0 and phase advances 0→1→2→3. The tick in phase 3 returns the block to IDLE.
- Stretch: when scl_oe_o==0 in RUN and scl_i==0, qcnt holds and no tick occurs.
- Phase outputs, given as (scl_oe, sda_oe) for phases p0/p1/p2/p3. Outputs are registered and take their phase values from the first cycle of the phase.
  - START: (1,0)/(0,0)/(0,1)/(1,1). Valid from idle or as a repeated start.
  - STOP: (1,1)/(0,1)/(0,0)/(0,0).
  - WRITE: (1,~d)/(0,~d)/(0,~d)/(1,~d).
  - READ: (1,0)/(0,0)/(0,0)/(1,0).
- Sample: sda_i is captured on the phase-2 tick of WRITE/READ.
- Completion: on the phase-3 tick of WRITE/READ, the next cycle shows rsp_valid_o=1 for exactly one cycle with rsp_bit_o=sample. The same cycle also shows busy_o=0 and cmd_ready_o=1.
- arb_lost_o=1 in that same cycle only if the command was WRITE, d=1 and sample=0. It does not abort anything; the upstream block decides.
- START/STOP produce no response.
- IDLE holds the last scl_oe_o/sda_oe_o values. After START/WRITE/READ, SCL is held low; after STOP, both lines are released. After reset, both lines are released.
- Latency: an unstretched command takes 4*QDIV cycles in RUN. Back-to-back commands have 1 IDLE cycle between them.
- cmd_valid_i while busy is ignored (not accepted). cmd_i and din_i changes during RUN have no effect.

Test Plan:
- CLK_IN=100, SCL_FREQ=5 (QDIV=5) for all tests.
- Reset mid-WRITE: assert arst_i during phase 2 → the same cycle shows scl_oe_o=0, sda_oe_o=0, busy_o=0, cmd_ready_o=1, and no rsp_valid_o.
- START from reset: accept at N → sda_oe_o=1 from N+11, scl_oe_o=1 from N+16, busy_o=0 at N+21, no rsp_valid_o.
- WRITE d=0 then READ with sda_i=1: WRITE holds sda_oe_o=1 for 20 cycles and pulses rsp_valid_o with rsp_bit_o=0. READ pulses rsp_valid_o 21 cycles after its accept with rsp_bit_o=1.
- Clock stretch: hold scl_i=0 for 7 cycles after READ phase 1 begins → completion is delayed exactly 7 cycles versus the unstretched run.
- Arbitration: WRITE d=1 with sda_i=0 → rsp_valid_o=1, rsp_bit_o=0, arb_lost_o=1 for one cycle. The next WRITE with d=1 and sda_i=1 gives arb_lost_o=0.
- STOP after WRITE: scl_oe_o/sda_oe_o sequence (1,1)/(0,1)/(0,0)/(0,0), 5 cycles each. IDLE then holds (0,0), and cmd_valid_i asserted during RUN is not accepted.
